// File: rtl/md_sched.sv
// md_sched: sequencer for the shared multiply/divide unit.
//
// Takes one mult/div instruction from the X stage, registers its operands,
// fires a one-cycle start pulse at the unit, and waits for unit_rdy or a
// watchdog timeout. It buffers the result and writes it through the shared
// regfile port in the first cycle the W stage leaves free. It also
// registers a one-cycle forwarding entry for the instruction that follows.
//
// State table:
//   S_IDLE   | no operation; stall mirrors issue_valid, issue latched here
//   S_LAUNCH | start pulse on ctrl_MULT/ctrl_DIV, watchdog cleared
//   S_BUSY   | waiting for unit_rdy or watchdog expiry
//   S_HOLD   | result buffered, waiting for a free regfile write slot
//
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   issue_valid/is_div/rd  instruction from the X stage
//   issue_a, issue_b       bypassed operands
//   md_a, md_b             registered operands to the unit
//   ctrl_MULT, ctrl_DIV    one-cycle start pulses
//   unit_result/exception  unit outputs, qualified by unit_rdy
//   wb_pipe_we             W stage is using the regfile write port
//   md_we/md_waddr/md_wdata  regfile write request
//   stall, kill_x          pipeline control
//   fwd_valid/rd/data      one-cycle forwarding entry
//   busy                   state is not IDLE
module md_sched #(
    parameter int MAX_WAIT = 64,
    parameter int EXC_REG  = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_is_div,
    input  logic [4:0]  issue_rd,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    input  logic [31:0] unit_result,
    input  logic        unit_exception,
    input  logic        unit_rdy,
    input  logic        wb_pipe_we,
    output logic        md_we,
    output logic [4:0]  md_waddr,
    output logic [31:0] md_wdata,
    output logic        stall,
    output logic        kill_x,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data,
    output logic        busy
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_BUSY,
        S_HOLD
    } state_t;

    state_t            state;
    logic              is_div_q;
    logic [4:0]        rd_q;
    logic [31:0]       result_q;
    logic              exc_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_cnt_nxt;
    logic              timeout;
    logic              wr_slot;

    always_comb begin
        wait_cnt_nxt = wait_cnt + CNT_W'(1);
        timeout      = (wait_cnt_nxt == CNT_W'(MAX_WAIT));

        // The slot is taken even for r0 so that HOLD always drains and the
        // following instruction sees a kill_x pulse; only the write is masked.
        wr_slot = (state == S_HOLD) && !wb_pipe_we;
        md_we   = wr_slot && (exc_q || (rd_q != 5'd0));
        kill_x  = wr_slot;

        md_waddr = exc_q ? 5'(EXC_REG) : rd_q;
        md_wdata = exc_q ? (is_div_q ? 32'd5 : 32'd4) : result_q;

        ctrl_MULT = (state == S_LAUNCH) && !is_div_q;
        ctrl_DIV  = (state == S_LAUNCH) &&  is_div_q;
        busy      = (state != S_IDLE);

        unique case (state)
            S_IDLE:   stall = issue_valid;
            S_LAUNCH: stall = 1'b1;
            S_BUSY:   stall = 1'b1;
            S_HOLD:   stall = wb_pipe_we;
            default:  stall = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            md_a      <= '0;
            md_b      <= '0;
            is_div_q  <= 1'b0;
            rd_q      <= '0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            wait_cnt  <= '0;
            fwd_valid <= 1'b0;
            fwd_rd    <= '0;
            fwd_data  <= '0;
        end else begin
            fwd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (issue_valid) begin
                        md_a     <= issue_a;
                        md_b     <= issue_b;
                        is_div_q <= issue_is_div;
                        rd_q     <= issue_rd;
                        state    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wait_cnt <= '0;
                    state    <= S_BUSY;
                end
                S_BUSY: begin
                    // A ready in the last watchdog cycle still delivers the real result.
                    if (unit_rdy) begin
                        result_q <= unit_result;
                        exc_q    <= unit_exception;
                        state    <= S_HOLD;
                    end else if (timeout) begin
                        result_q <= '0;
                        exc_q    <= 1'b1;
                        state    <= S_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt_nxt;
                    end
                end
                S_HOLD: begin
                    if (wr_slot) begin
                        fwd_valid <= md_we;
                        if (md_we) begin
                            fwd_rd   <= md_waddr;
                            fwd_data <= md_wdata;
                        end
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched. Each operation's expected timeline and
// write are derived arithmetically from its issue cycle, ready delay and
// write-port contention, then compared with what the DUT shows cycle by cycle.
module tb_md_sched;

    localparam int MAX_WAIT = 64;
    localparam int EXC_REG  = 30;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_is_div = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [31:0] issue_a = '0;
    logic [31:0] issue_b = '0;
    logic [31:0] md_a, md_b;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] unit_result = '0;
    logic        unit_exception = 1'b0;
    logic        unit_rdy = 1'b0;
    logic        wb_pipe_we = 1'b0;
    logic        md_we;
    logic [4:0]  md_waddr;
    logic [31:0] md_wdata;
    logic        stall, kill_x;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        busy;

    md_sched #(.MAX_WAIT(MAX_WAIT), .EXC_REG(EXC_REG)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_is_div(issue_is_div), .issue_rd(issue_rd),
        .issue_a(issue_a), .issue_b(issue_b),
        .md_a(md_a), .md_b(md_b), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .unit_result(unit_result), .unit_exception(unit_exception), .unit_rdy(unit_rdy),
        .wb_pipe_we(wb_pipe_we),
        .md_we(md_we), .md_waddr(md_waddr), .md_wdata(md_wdata),
        .stall(stall), .kill_x(kill_x),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Forwarding entry the model expects in the cycle after the last write slot.
    bit          pend_live = 1'b0;
    bit          pend_valid;
    logic [4:0]  pend_rd;
    logic [31:0] pend_data;

    // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        issue_valid = 1'($urandom_range(0, 1));
        unit_rdy = 1'($urandom_range(0, 1));
        wb_pipe_we = 1'($urandom_range(0, 1));
        tick();
        issue_valid = 1'($urandom_range(0, 1));
        unit_rdy = 1'($urandom_range(0, 1));
        tick();
        reset = 1'b0;
        issue_valid = 1'b0;
        unit_rdy = 1'b0;
        wb_pipe_we = 1'b0;
        pend_live = 1'b0;
    endtask

    task automatic idle_cycle(input string name);
        tick();
        issue_valid = 1'b0;
        unit_rdy = 1'($urandom_range(0, 1));
        unit_result = $urandom;
        wb_pipe_we = 1'($urandom_range(0, 1));
        #1;
        if (pend_live) begin
            n_checks++;
            if (fwd_valid !== pend_valid) $display("FAIL %s fwd_valid: got %0b want %0b", name, fwd_valid, pend_valid);
            else n_pass++;
            if (pend_valid) begin
                n_checks++;
                if (fwd_rd !== pend_rd || fwd_data !== pend_data)
                    $display("FAIL %s fwd_entry: got r%0d=%0h want r%0d=%0h", name, fwd_rd, fwd_data, pend_rd, pend_data);
                else n_pass++;
            end
            pend_live = 1'b0;
        end else begin
            n_checks++;
            if (fwd_valid !== 1'b0) $display("FAIL %s fwd_clear: got %0b want 0", name, fwd_valid);
            else n_pass++;
        end
        n_checks++;
        if (busy !== 1'b0 || stall !== 1'b0 || md_we !== 1'b0)
            $display("FAIL %s idle_outputs: got busy=%0b stall=%0b we=%0b want 0 0 0", name, busy, stall, md_we);
        else n_pass++;
    endtask

    // One full operation starting from IDLE. rdy_dly is the BUSY cycle index in
    // which unit_rdy is raised (-1 = never); wb_busy is the number of HOLD
    // cycles in which the W stage occupies the port.
    task automatic run_op(input string name, input bit is_div, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b, input int rdy_dly,
                          input bit exc, input int wb_busy, input logic [31:0] res);
        int          hold_at, leave_at;
        bit          eff_exc, exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        int          mult_n, div_n, pulse_t, we_n, we_t, kill_n, kill_t;
        int          stall_bad, busy_bad, fwd_bad;
        logic [4:0]  we_addr;
        logic [31:0] we_data, a_seen, b_seen, a_late;

        hold_at  = 2 + ((rdy_dly >= 0) ? rdy_dly + 1 : MAX_WAIT);
        leave_at = hold_at + wb_busy;
        eff_exc  = exc || (rdy_dly < 0);
        exp_addr = eff_exc ? 5'(EXC_REG) : rd;
        exp_data = eff_exc ? (is_div ? 32'd5 : 32'd4) : res;
        exp_we   = eff_exc || (rd != 5'd0);

        mult_n = 0; div_n = 0; pulse_t = -1; we_n = 0; we_t = -1; kill_n = 0; kill_t = -1;
        stall_bad = 0; busy_bad = 0; fwd_bad = 0;
        we_addr = '0; we_data = '0; a_seen = '0; b_seen = '0; a_late = '0;

        for (int t = 0; t <= leave_at; t++) begin
            tick();
            if (t == 0) begin
                issue_valid = 1'b1; issue_is_div = is_div; issue_rd = rd;
                issue_a = a; issue_b = b;
            end else begin
                issue_valid = 1'($urandom_range(0, 1)); issue_is_div = 1'($urandom_range(0, 1));
                issue_rd = 5'($urandom); issue_a = $urandom; issue_b = $urandom;
            end
            if (rdy_dly >= 0 && t == 2 + rdy_dly) begin
                unit_rdy = 1'b1; unit_result = res; unit_exception = exc;
            end else if (t < 2 || t >= hold_at) begin
                unit_rdy = 1'($urandom_range(0, 1)); unit_result = $urandom;
                unit_exception = 1'($urandom_range(0, 1));
            end else begin
                unit_rdy = 1'b0; unit_result = $urandom; unit_exception = 1'($urandom_range(0, 1));
            end
            wb_pipe_we = (t >= hold_at) ? (t < leave_at) : 1'($urandom_range(0, 1));
            #1;
            if (t == 0 && pend_live) begin
                n_checks++;
                if (fwd_valid !== pend_valid) $display("FAIL %s fwd_valid: got %0b want %0b", name, fwd_valid, pend_valid);
                else n_pass++;
                if (pend_valid) begin
                    n_checks++;
                    if (fwd_rd !== pend_rd || fwd_data !== pend_data)
                        $display("FAIL %s fwd_entry: got r%0d=%0h want r%0d=%0h", name, fwd_rd, fwd_data, pend_rd, pend_data);
                    else n_pass++;
                end
                pend_live = 1'b0;
            end
            if (ctrl_MULT) begin mult_n++; pulse_t = t; end
            if (ctrl_DIV)  begin div_n++;  pulse_t = t; end
            if (md_we) begin we_n++; we_t = t; we_addr = md_waddr; we_data = md_wdata; end
            if (kill_x) begin kill_n++; kill_t = t; end
            if (stall !== (t < leave_at)) stall_bad++;
            if (busy !== (t >= 1)) busy_bad++;
            if (t >= 1 && fwd_valid !== 1'b0) fwd_bad++;
            if (t == 1) begin a_seen = md_a; b_seen = md_b; end
            if (t == leave_at) a_late = md_a;
        end

        n_checks++;
        if (mult_n !== (is_div ? 0 : 1)) $display("FAIL %s mult_pulses: got %0d want %0d", name, mult_n, is_div ? 0 : 1);
        else n_pass++;
        n_checks++;
        if (div_n !== (is_div ? 1 : 0)) $display("FAIL %s div_pulses: got %0d want %0d", name, div_n, is_div ? 1 : 0);
        else n_pass++;
        n_checks++;
        if (pulse_t !== 1) $display("FAIL %s pulse_cycle: got c+%0d want c+1", name, pulse_t);
        else n_pass++;
        n_checks++;
        if (we_n !== (exp_we ? 1 : 0)) $display("FAIL %s write_count: got %0d want %0d", name, we_n, exp_we ? 1 : 0);
        else n_pass++;
        if (exp_we) begin
            n_checks++;
            if (we_t !== leave_at) $display("FAIL %s write_cycle: got c+%0d want c+%0d", name, we_t, leave_at);
            else n_pass++;
            n_checks++;
            if (we_addr !== exp_addr || we_data !== exp_data)
                $display("FAIL %s write_value: got r%0d=%0h want r%0d=%0h", name, we_addr, we_data, exp_addr, exp_data);
            else n_pass++;
        end
        n_checks++;
        if (kill_n !== 1 || kill_t !== leave_at)
            $display("FAIL %s kill_x: got %0d pulses last at c+%0d want 1 at c+%0d", name, kill_n, kill_t, leave_at);
        else n_pass++;
        n_checks++;
        if (stall_bad !== 0) $display("FAIL %s stall: got %0d wrong cycles want 0", name, stall_bad);
        else n_pass++;
        n_checks++;
        if (busy_bad !== 0) $display("FAIL %s busy: got %0d wrong cycles want 0", name, busy_bad);
        else n_pass++;
        n_checks++;
        if (fwd_bad !== 0) $display("FAIL %s fwd_early: got %0d cycles valid want 0", name, fwd_bad);
        else n_pass++;
        n_checks++;
        if (a_seen !== a || b_seen !== b || a_late !== a)
            $display("FAIL %s operands: got a=%0h b=%0h late_a=%0h want a=%0h b=%0h", name, a_seen, b_seen, a_late, a, b);
        else n_pass++;

        pend_live  = 1'b1;
        pend_valid = exp_we;
        pend_rd    = exp_addr;
        pend_data  = exp_data;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (md_a !== 32'd0 || md_b !== 32'd0) $display("FAIL reset operands: got %0h %0h want 0 0", md_a, md_b);
        else n_pass++;
        n_checks++;
        if (md_waddr !== 5'd0 || md_wdata !== 32'd0) $display("FAIL reset write_bus: got %0d %0h want 0 0", md_waddr, md_wdata);
        else n_pass++;
        n_checks++;
        if (fwd_valid !== 1'b0 || fwd_rd !== 5'd0 || fwd_data !== 32'd0)
            $display("FAIL reset fwd: got %0b %0d %0h want 0 0 0", fwd_valid, fwd_rd, fwd_data);
        else n_pass++;
        n_checks++;
        if ({md_we, ctrl_MULT, ctrl_DIV, kill_x, busy, stall} !== 6'b0)
            $display("FAIL reset controls: got %06b want 000000", {md_we, ctrl_MULT, ctrl_DIV, kill_x, busy, stall});
        else n_pass++;
        issue_valid = 1'b1;
        issue_a = 32'hA5A5_0001;
        #1;
        n_checks++;
        if (stall !== 1'b1) $display("FAIL reset stall_follows_issue: got %0b want 1", stall);
        else n_pass++;
        n_checks++;
        if (md_a !== 32'd0) $display("FAIL reset no_comb_operand: got %0h want 0", md_a);
        else n_pass++;
        issue_valid = 1'b0;
        #1;
    endtask

    task automatic test_mul_basic();
        run_op("mul_7x6", 1'b0, 5'd5, 32'd7, 32'd6, 2, 1'b0, 0, 32'd42);
        idle_cycle("mul_7x6_after");
        idle_cycle("mul_7x6_clear");
    endtask

    task automatic test_div_exception();
        run_op("div_by_0", 1'b1, 5'd9, $urandom, 32'd0, 3, 1'b1, 0, $urandom);
        idle_cycle("div_by_0_after");
    endtask

    task automatic test_wb_conflict();
        logic [31:0] a, b;
        a = $urandom_range(1, 60000);
        b = $urandom_range(1, 60000);
        run_op("wb_conflict", 1'b0, 5'd12, a, b, 1, 1'b0, 3, a * b);
        idle_cycle("wb_conflict_after");
    endtask

    task automatic test_watchdog();
        run_op("watchdog", 1'b0, 5'd17, $urandom, $urandom, -1, 1'b0, 0, 32'd0);
        idle_cycle("watchdog_after");
        // Ready in the final watchdog cycle wins over the timeout.
        run_op("watchdog_edge", 1'b1, 5'd3, 32'd100, 32'd7, MAX_WAIT - 1, 1'b0, 1, 32'd14);
        idle_cycle("watchdog_edge_after");
    endtask

    task automatic test_reset_mid();
        int bad;
        tick();
        issue_valid = 1'b1; issue_is_div = 1'b0; issue_rd = 5'd7;
        issue_a = 32'h1234_5678; issue_b = 32'h0000_0FFF;
        unit_rdy = 1'b0; wb_pipe_we = 1'b0;
        tick();
        issue_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        unit_rdy = 1'b1; unit_result = 32'hDEAD_BEEF; unit_exception = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || md_a !== 32'd0 || md_b !== 32'd0)
            $display("FAIL reset_mid state: got busy=%0b a=%0h b=%0h want 0 0 0", busy, md_a, md_b);
        else n_pass++;
        n_checks++;
        if (md_waddr !== 5'd0 || md_wdata !== 32'd0 || fwd_valid !== 1'b0 || md_we !== 1'b0)
            $display("FAIL reset_mid outputs: got %0d %0h %0b %0b want 0 0 0 0", md_waddr, md_wdata, fwd_valid, md_we);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            unit_rdy = 1'($urandom_range(0, 1)); unit_result = $urandom;
            wb_pipe_we = 1'b0;
            #1;
            if (md_we || ctrl_MULT || ctrl_DIV || kill_x || busy) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL reset_mid abandoned: got %0d active cycles want 0", bad);
        else n_pass++;
        unit_rdy = 1'b0;
        pend_live = 1'b0;
        run_op("reset_mid_fresh", 1'b0, 5'd7, 32'd300, 32'd3, 0, 1'b0, 0, 32'd900);
        idle_cycle("reset_mid_fresh_after");
    endtask

    task automatic test_rd0_back_to_back();
        run_op("rd0", 1'b0, 5'd0, 32'd11, 32'd13, 1, 1'b0, 1, 32'd143);
        run_op("rd0_next", 1'b1, 5'd21, 32'd99, 32'd9, 0, 1'b0, 0, 32'd11);
        run_op("rd0_next2", 1'b0, 5'd22, 32'd5, 32'd5, 4, 1'b0, 0, 32'd25);
        idle_cycle("rd0_after");
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            bit          is_div, exc;
            logic [4:0]  rd;
            logic [31:0] a, b, res;
            int          dly, wb;
            is_div = 1'($urandom_range(0, 1));
            rd  = 5'($urandom);
            a   = $urandom;
            b   = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            exc = ($urandom_range(0, 7) == 0);
            if (is_div) begin
                if (b == 32'd0) begin exc = 1'b1; res = $urandom; end
                else res = a / b;
            end else begin
                res = a * b;
            end
            dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 12));
            wb  = int'($urandom_range(0, 3));
            run_op($sformatf("random_%0d", n), is_div, rd, a, b, dly, exc, wb, res);
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) idle_cycle($sformatf("random_%0d_gap", n));
        end
        idle_cycle("random_tail");
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_div_exception();
        test_wb_conflict();
        test_watchdog();
        test_reset_mid();
        test_rd0_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
